// File: rtl/gate_tb_pkg.sv
// Shared definitions for the gate-stage stimulus generator: FSM states, default
// LFSR polynomial/seeds and width-generic (up to 64 bit) LFSR helper functions.
package gate_tb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALK = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int unsigned MAX_WIDTH     = 64;
    localparam logic [63:0] DEFAULT_POLY  = 64'hD800_0000_0000_0000;
    localparam logic [63:0] DEFAULT_SEED1 = 64'h1;
    localparam logic [63:0] DEFAULT_SEED2 = 64'h2;
    localparam logic [63:0] DEFAULT_SEED3 = 64'h3;

    // Mask of the low w bits; w >= 64 yields all ones.
    function automatic logic [63:0] width_mask(input int unsigned w);
        if (w >= MAX_WIDTH) begin
            return '1;
        end
        return (64'h1 << w) - 64'h1;
    endfunction

    // An all-zero seed would lock the LFSR, so it is replaced by all ones.
    function automatic logic [63:0] seed_fix(input logic [63:0] seed, input int unsigned w);
        logic [63:0] masked;
        masked = seed & width_mask(w);
        return (masked == 64'h0) ? width_mask(w) : masked;
    endfunction

    // Right-shift Galois step; callers zero-extend narrower states and mask poly.
    function automatic logic [63:0] lfsr_step(input logic [63:0] s, input logic [63:0] poly);
        return (s >> 1) ^ (s[0] ? poly : 64'h0);
    endfunction

endpackage

// File: rtl/gate_vec_gen_if.sv
// Operand/handshake bundle between the stimulus generator (master) and the
// gate stage / checker (slave).
interface gate_vec_gen_if #(
    parameter int unsigned WIDTH = 64
);
    logic             start;
    logic             out_ready;
    logic             out_valid;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [WIDTH-1:0] in3;
    logic [31:0]      vec_idx;
    logic             busy;
    logic             done;

    modport master (
        input  start,
        input  out_ready,
        output out_valid,
        output in1,
        output in2,
        output in3,
        output vec_idx,
        output busy,
        output done
    );

    modport slave (
        output start,
        output out_ready,
        input  out_valid,
        input  in1,
        input  in2,
        input  in3,
        input  vec_idx,
        input  busy,
        input  done
    );
endinterface

// File: rtl/gate_vec_gen_lfsr_galois.sv
// Galois LFSR with seed load and step enable; an all-zero seed is replaced by
// all ones so the register can never lock up.
module lfsr_galois
    import gate_tb_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter logic [63:0] POLY  = DEFAULT_POLY,
    parameter logic [63:0] SEED  = DEFAULT_SEED1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    output logic [WIDTH-1:0] state
);

    localparam logic [WIDTH-1:0] SEED_W = WIDTH'(seed_fix(SEED, WIDTH));
    localparam logic [63:0]      POLY_M = POLY & width_mask(WIDTH);

    logic [WIDTH-1:0] state_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= SEED_W;
        end else if (load) begin
            state_reg <= SEED_W;
        end else if (step) begin
            state_reg <= WIDTH'(lfsr_step(64'(state_reg), POLY_M));
        end
    end

    assign state = state_reg;

endmodule

// File: rtl/gate_vec_gen.sv
// Reproducible pseudo-random operand generator for the gate stage: a start pulse
// emits NUM_VEC vectors over valid/ready. Define GATE_VEC_GEN_WALK_EN to prepend
// a WIDTH-vector walking-one phase. Supports WIDTH in 2..64.
module gate_vec_gen
    import gate_tb_pkg::*;
#(
    parameter int unsigned WIDTH   = 64,
    parameter int unsigned NUM_VEC = 256,
    parameter logic [63:0] POLY    = DEFAULT_POLY,
    parameter logic [63:0] SEED1   = DEFAULT_SEED1,
    parameter logic [63:0] SEED2   = DEFAULT_SEED2,
    parameter logic [63:0] SEED3   = DEFAULT_SEED3
) (
    input  logic           clk,
    input  logic           rst,
    gate_vec_gen_if.master bus
);

    localparam logic [63:0] POLY_M     = POLY & width_mask(WIDTH);
    localparam logic [63:0] SEEDS [3]  = '{SEED1, SEED2, SEED3};
    localparam logic [31:0] RUN_LAST   = 32'(NUM_VEC - 1);

    state_t           state_reg;
    state_t           state_next;

    logic             out_valid_reg;
    logic             out_valid_next;
    logic             busy_reg;
    logic             busy_next;
    logic             done_reg;
    logic             done_next;
    logic [31:0]      vec_idx_reg;
    logic [31:0]      vec_idx_next;
    logic [WIDTH-1:0] in_reg  [3];
    logic [WIDTH-1:0] in_next [3];

    logic [WIDTH-1:0] lfsr_state [3];
    logic [WIDTH-1:0] lfsr_next  [3];
    logic [WIDTH-1:0] seed_w     [3];
    logic             lfsr_load;
    logic             lfsr_adv;

    logic             xfer;
    logic             run_last;

    assign xfer     = out_valid_reg & bus.out_ready;
    assign run_last = (vec_idx_reg == RUN_LAST);

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_lfsr
            lfsr_galois #(
                .WIDTH (WIDTH),
                .POLY  (POLY),
                .SEED  (SEEDS[gi])
            ) u_lfsr (
                .clk   (clk),
                .rst   (rst),
                .load  (lfsr_load),
                .step  (lfsr_adv),
                .state (lfsr_state[gi])
            );

            // Output registers track the LFSR, so they need its successor value.
            assign lfsr_next[gi] = WIDTH'(lfsr_step(64'(lfsr_state[gi]), POLY_M));
            assign seed_w[gi]    = WIDTH'(seed_fix(SEEDS[gi], WIDTH));
        end
    endgenerate

`ifdef GATE_VEC_GEN_WALK_EN
    localparam state_t      FIRST_PHASE = WALK;
    localparam logic [31:0] WALK_LAST   = 32'(WIDTH - 1);

    logic walk_last;
    assign walk_last = (vec_idx_reg == WALK_LAST);

    function automatic logic [WIDTH-1:0] walk_one(input logic [31:0] k);
        return WIDTH'(1) << k;
    endfunction
`else
    localparam state_t FIRST_PHASE = RUN;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next = FIRST_PHASE;
                end
            end
`ifdef GATE_VEC_GEN_WALK_EN
            WALK: begin
                if (xfer && walk_last) begin
                    state_next = RUN;
                end
            end
`endif
            RUN: begin
                if (xfer && run_last) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        vec_idx_next = vec_idx_reg;
        for (int i = 0; i < 3; i++) begin
            in_next[i] = in_reg[i];
        end
        lfsr_load = 1'b0;
        lfsr_adv  = 1'b0;

        unique case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    lfsr_load    = 1'b1;
                    vec_idx_next = '0;
`ifdef GATE_VEC_GEN_WALK_EN
                    in_next[0] = walk_one(32'd0);
                    in_next[1] = ~walk_one(32'd0);
                    in_next[2] = '0;
`else
                    for (int i = 0; i < 3; i++) begin
                        in_next[i] = seed_w[i];
                    end
`endif
                end
            end
`ifdef GATE_VEC_GEN_WALK_EN
            WALK: begin
                if (xfer) begin
                    if (walk_last) begin
                        // LFSRs were loaded at start and left untouched: they still hold the seeds.
                        vec_idx_next = '0;
                        for (int i = 0; i < 3; i++) begin
                            in_next[i] = lfsr_state[i];
                        end
                    end else begin
                        vec_idx_next = vec_idx_reg + 32'd1;
                        in_next[0]   = walk_one(vec_idx_next);
                        in_next[1]   = ~walk_one(vec_idx_next);
                        in_next[2]   = {WIDTH{vec_idx_next[0]}};
                    end
                end
            end
`endif
            RUN: begin
                if (xfer) begin
                    lfsr_adv     = 1'b1;
                    vec_idx_next = vec_idx_reg + 32'd1;
                    for (int i = 0; i < 3; i++) begin
                        in_next[i] = lfsr_next[i];
                    end
                end
            end
            default: begin
            end
        endcase

`ifdef GATE_VEC_GEN_WALK_EN
        out_valid_next = (state_next == RUN) || (state_next == WALK);
`else
        out_valid_next = (state_next == RUN);
`endif
        busy_next = (state_next != IDLE);
        done_next = (state_next == DONE);
    end

    // Status flags are registered from the next state so all outputs come from flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            vec_idx_reg   <= '0;
            for (int i = 0; i < 3; i++) begin
                in_reg[i] <= '0;
            end
        end else begin
            out_valid_reg <= out_valid_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            vec_idx_reg   <= vec_idx_next;
            for (int i = 0; i < 3; i++) begin
                in_reg[i] <= in_next[i];
            end
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.busy      = busy_reg;
    assign bus.done      = done_reg;
    assign bus.vec_idx   = vec_idx_reg;
    assign bus.in1       = in_reg[0];
    assign bus.in2       = in_reg[1];
    assign bus.in3       = in_reg[2];

endmodule

// File: tb/tb_gate_vec_gen.sv
// Self-checking bench for gate_vec_gen: random-ready runs compared against a
// queue-based reference built from the LFSR rules (walk phase when compiled in).
module tb_gate_vec_gen;
    import gate_tb_pkg::*;

    localparam int unsigned WIDTH   = 64;
    localparam int unsigned NUM_VEC = 12;
`ifdef GATE_VEC_GEN_WALK_EN
    localparam int NW = WIDTH;
`else
    localparam int NW = 0;
`endif
    localparam int TOTAL  = NW + NUM_VEC;
    localparam int BUDGET = 4000;

    logic clk = 1'b0;
    logic rst;

    gate_vec_gen_if #(.WIDTH(WIDTH)) bus ();

    gate_vec_gen #(
        .WIDTH   (WIDTH),
        .NUM_VEC (NUM_VEC),
        .SEED1   (64'h1),
        .SEED2   (64'h2),
        .SEED3   (64'h0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [63:0] m1 [$];
    logic [63:0] m2 [$];
    logic [63:0] m3 [$];
    logic [31:0] mi [$];

    // Expected transfer sequence of one run; bus 3 uses seed 0, hence all ones.
    task automatic build_model();
        logic [63:0] s [3];
        s[0] = 64'h1;
        s[1] = 64'h2;
        s[2] = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int k = 0; k < NW; k++) begin
            m1.push_back(64'h1 << k);
            m2.push_back(~(64'h1 << k));
            m3.push_back((k % 2 == 1) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0);
            mi.push_back(32'(k));
        end
        for (int v = 0; v < int'(NUM_VEC); v++) begin
            m1.push_back(s[0]);
            m2.push_back(s[1]);
            m3.push_back(s[2]);
            mi.push_back(32'(v));
            for (int b = 0; b < 3; b++) begin
                if (s[b] % 2 == 1) s[b] = (s[b] / 2) ^ 64'hD800_0000_0000_0000;
                else               s[b] = s[b] / 2;
            end
        end
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags valid=%b busy=%b done=%b want 0 0 0", bus.out_valid, bus.busy, bus.done);
        end
        checks++;
        if (bus.vec_idx !== 32'd0 || bus.in1 !== '0 || bus.in2 !== '0 || bus.in3 !== '0) begin
            failures++;
            $display("FAIL reset_data idx=%0d in1=%h in2=%h in3=%h want all 0", bus.vec_idx, bus.in1, bus.in2, bus.in3);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_quiet valid=%b busy=%b want 0 0", bus.out_valid, bus.busy);
        end
    endtask

    task automatic test_golden();
        int n   = 0;
        int cyc = 0;
        bus.out_ready = 1'b1;
        pulse_start();
        while (n < TOTAL && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.busy !== 1'b1) begin
                    failures++;
                    $display("FAIL start_latency valid=%b busy=%b want 1 1", bus.out_valid, bus.busy);
                end
            end
            if (bus.out_valid === 1'b1) begin
                $display("xfer golden n=%0d idx=%0d in1=%h in2=%h in3=%h", n, bus.vec_idx, bus.in1, bus.in2, bus.in3);
                checks++;
                if (bus.vec_idx !== mi[n]) begin
                    failures++;
                    $display("FAIL golden_idx n=%0d got=%0d want=%0d", n, bus.vec_idx, mi[n]);
                end
                if (n == NW) begin
                    checks++;
                    if (bus.in1 !== 64'h1 || bus.vec_idx !== 32'd0) begin
                        failures++;
                        $display("FAIL golden_v0 in1=%h idx=%0d want 1 0", bus.in1, bus.vec_idx);
                    end
                end
                if (n == NW + 1) begin
                    checks++;
                    if (bus.in1 !== 64'hD800_0000_0000_0000) begin
                        failures++;
                        $display("FAIL golden_v1 in1=%h want d800000000000000", bus.in1);
                    end
                end
                if (n == NW + 2) begin
                    checks++;
                    if (bus.in1 !== 64'h6C00_0000_0000_0000) begin
                        failures++;
                        $display("FAIL golden_v2 in1=%h want 6c00000000000000", bus.in1);
                    end
                end
                n++;
            end
        end
        checks++;
        if (n != TOTAL || cyc != TOTAL) begin
            failures++;
            $display("FAIL golden_count transfers=%0d cycles=%0d want %0d %0d", n, cyc, TOTAL, TOTAL);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL golden_done done=%b valid=%b busy=%b want 1 0 1", bus.done, bus.out_valid, bus.busy);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL golden_idle done=%b busy=%b want 0 0", bus.done, bus.busy);
        end
    endtask

    task automatic test_stall();
        int n       = 0;
        int cyc     = 0;
        bit stalled = 1'b0;
        logic [63:0] s1, s2, s3;
        logic [31:0] si;
        bus.out_ready = 1'b1;
        pulse_start();
        while (n < TOTAL && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
            if (!stalled && n == NW + 2 && bus.out_valid === 1'b1) begin
                stalled       = 1'b1;
                bus.out_ready = 1'b0;
                s1 = bus.in1; s2 = bus.in2; s3 = bus.in3; si = bus.vec_idx;
                repeat (5) begin
                    @(negedge clk);
                    cyc++;
                    checks++;
                    if (bus.out_valid !== 1'b1 || bus.in1 !== s1 || bus.in2 !== s2 || bus.in3 !== s3 || bus.vec_idx !== si) begin
                        failures++;
                        $display("FAIL stall_hold valid=%b idx=%0d in1=%h want 1 %0d %h", bus.out_valid, bus.vec_idx, bus.in1, si, s1);
                    end
                end
                bus.out_ready = 1'b1;
            end
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                $display("xfer stall n=%0d idx=%0d in1=%h in2=%h in3=%h", n, bus.vec_idx, bus.in1, bus.in2, bus.in3);
                checks++;
                if (bus.in1 !== m1[n] || bus.in2 !== m2[n] || bus.in3 !== m3[n] || bus.vec_idx !== mi[n]) begin
                    failures++;
                    $display("FAIL stall_vec n=%0d got idx=%0d in1=%h in2=%h in3=%h want idx=%0d in1=%h in2=%h in3=%h",
                             n, bus.vec_idx, bus.in1, bus.in2, bus.in3, mi[n], m1[n], m2[n], m3[n]);
                end
                n++;
            end
        end
        checks++;
        if (n != TOTAL) begin
            failures++;
            $display("FAIL stall_timeout transfers=%0d want %0d", n, TOTAL);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b1 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL stall_done done=%b valid=%b want 1 0", bus.done, bus.out_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_random_ready();
        int n   = 0;
        int cyc = 0;
        bus.out_ready = 1'b0;
        pulse_start();
        while (n < TOTAL && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.start     = (cyc == 4);
            if (bus.out_valid === 1'b1) begin
                checks++;
                if (bus.in1 !== m1[n] || bus.in2 !== m2[n] || bus.in3 !== m3[n] || bus.vec_idx !== mi[n]) begin
                    failures++;
                    $display("FAIL rand_vec n=%0d got idx=%0d in1=%h in2=%h in3=%h want idx=%0d in1=%h in2=%h in3=%h",
                             n, bus.vec_idx, bus.in1, bus.in2, bus.in3, mi[n], m1[n], m2[n], m3[n]);
                end
                if (bus.out_ready) begin
                    $display("xfer rand n=%0d idx=%0d in1=%h in2=%h in3=%h", n, bus.vec_idx, bus.in1, bus.in2, bus.in3);
                    n++;
                end
            end
        end
        bus.start = 1'b0;
        checks++;
        if (n != TOTAL) begin
            failures++;
            $display("FAIL rand_timeout transfers=%0d want %0d", n, TOTAL);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b1 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rand_done done=%b valid=%b want 1 0", bus.done, bus.out_valid);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL rand_no_requeue valid=%b busy=%b done=%b want 0 0 0", bus.out_valid, bus.busy, bus.done);
        end
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b1;
        pulse_start();
        for (int r = 0; r < 2; r++) begin
            int n   = 0;
            int cyc = 0;
            while (n < TOTAL && cyc < BUDGET) begin
                @(negedge clk);
                cyc++;
                if (bus.out_valid === 1'b1) begin
                    $display("xfer b2b run=%0d n=%0d idx=%0d in1=%h in2=%h in3=%h", r, n, bus.vec_idx, bus.in1, bus.in2, bus.in3);
                    checks++;
                    if (bus.in1 !== m1[n] || bus.in2 !== m2[n] || bus.in3 !== m3[n] || bus.vec_idx !== mi[n]) begin
                        failures++;
                        $display("FAIL b2b_vec run=%0d n=%0d got in1=%h idx=%0d want in1=%h idx=%0d",
                                 r, n, bus.in1, bus.vec_idx, m1[n], mi[n]);
                    end
                    n++;
                end
            end
            @(negedge clk);
            checks++;
            if (n != TOTAL || bus.done !== 1'b1) begin
                failures++;
                $display("FAIL b2b_end run=%0d transfers=%0d done=%b want %0d 1", r, n, bus.done, TOTAL);
            end
            // Start lands in the idle cycle right after done.
            if (r == 0) pulse_start();
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int n   = 0;
        int cyc = 0;
        bus.out_ready = 1'b1;
        pulse_start();
        while (n < NW + 10 && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
            if (bus.out_valid === 1'b1) n++;
        end
        @(negedge clk);
        checks++;
        if (bus.vec_idx !== 32'd10 || bus.out_valid !== 1'b1) begin
            failures++;
            $display("FAIL rst_reach idx=%0d valid=%b want 10 1", bus.vec_idx, bus.out_valid);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.vec_idx !== 32'd0 || bus.in1 !== '0) begin
            failures++;
            $display("FAIL rst_async valid=%b busy=%b idx=%0d in1=%h want 0 0 0 0", bus.out_valid, bus.busy, bus.vec_idx, bus.in1);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        pulse_start();
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.in1 !== m1[0] || bus.in3 !== m3[0] || bus.vec_idx !== 32'd0) begin
            failures++;
            $display("FAIL rst_restart valid=%b in1=%h in3=%h idx=%0d want 1 %h %h 0", bus.out_valid, bus.in1, bus.in3, bus.vec_idx, m1[0], m3[0]);
        end
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (bus.done !== 1'b1) begin
            failures++;
            $display("FAIL rst_rerun_timeout done=%b want 1", bus.done);
        end
        @(negedge clk);
    endtask

    initial begin
        build_model();
        test_reset();
        test_golden();
        test_stall();
        test_random_ready();
        test_back_to_back();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gate_vec_gen.md
# gate_vec_gen

Stimulus generator that sits directly upstream of the gate test top and drives its three 64-bit operand buses (in1, in2, in3) with reproducible pseudo-random vectors. A start pulse launches a run of NUM_VEC vectors delivered over a valid/ready handshake, so a downstream checker can stall it. It replaces C-side stimulus with an on-chip source, so the same gate stage can run standalone in simulation or on FPGA.

## Interface
- WIDTH, 64: operand width; must be ≥ 2.
- NUM_VEC, 256: vectors per random phase; range 1..2^32-1.
- POLY, 64'hD800_0000_0000_0000: Galois LFSR tap mask, right-shift form (x^64+x^63+x^61+x^60+1); only the low WIDTH bits are used.
- SEED1 / SEED2 / SEED3, 64'h1 / 64'h2 / 64'h3: per-bus LFSR seeds; only the low WIDTH bits are used.

- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  one-cycle request to begin a run; ignored unless the FSM is IDLE.
- out_ready  in  1  downstream accepts the current vector.
- out_valid  out  1  in1/in2/in3 hold a valid vector.
- in1, in2, in3  out  WIDTH  operand buses to the gate stage.
- vec_idx  out  32  index of the current vector within its phase, starting at 0.
- busy  out  1  FSM is not IDLE.
- done  out  1  one-cycle pulse after the final transfer.

## Operation
- FSM states: IDLE, WALK (only if the macro is defined), RUN, DONE.
- IDLE, start=1:
  - load the three LFSRs with their seeds; a seed of 0 is replaced by all-ones;
  - clear vec_idx;
  - go to WALK if compiled in, else RUN.
- RUN:
  - out_valid=1; in1/in2/in3 = LFSR1/2/3 state.
  - On out_valid & out_ready: each LFSR steps next = (s>>1) ^ (s[0] ? POLY : 0) and vec_idx increments.
  - On the transfer where vec_idx == NUM_VEC-1: go to DONE and drop out_valid.
- DONE: done=1 for exactly one cycle, then IDLE.
- Stall: while out_valid & !out_ready, in1/in2/in3, vec_idx and the LFSRs hold stable.
- out_valid never drops without a completed transfer, except on reset.
- start while busy: ignored and not queued.
- Every run reloads the seeds, so back-to-back runs produce identical sequences.
- vec_idx is 32 bits and does not wrap within a legal run.

## Timing
- Reset values: out_valid=0, busy=0, done=0, vec_idx=0, in1/in2/in3=0, LFSRs=seeds, FSM=IDLE. These apply immediately on rst assertion.
- Reset mid-run: the run is abandoned; the next start after rst deasserts begins a fresh run from the seeds.
- start sampled high at edge t: busy=1 and out_valid=1 after edge t, first vector = seeds.
- Throughput: one vector per cycle while out_ready=1.
- With out_ready held high, the run lasts NUM_VEC cycles of valid, plus one DONE cycle.
- done asserts the cycle after the last transfer; out_valid is 0 in that cycle.
- busy falls together with done's deassertion; a start in the cycle after done is accepted.
- All outputs are registered; there is no combinational path from out_ready to any output.

## Configuration
- GATE_VEC_GEN_WALK_EN defined: a WALK phase of WIDTH vectors precedes RUN.
  - Vector k: in1 = 1<<k, in2 = ~(1<<k), in3 = {WIDTH{k[0]}}.
  - vec_idx counts 0..WIDTH-1, then resets to 0 on entry to RUN.
  - The LFSRs do not step during WALK.
- GATE_VEC_GEN_WALK_EN undefined: the WALK state and its logic are absent; start goes straight to RUN.

## Structure
- Shared package gate_tb_pkg holds:
  - the state enum (IDLE, WALK, RUN, DONE);
  - the default POLY;
  - the default seeds;
  - the lfsr_step function (pure combinational next-state).
- One sub-module: lfsr_galois (parameters WIDTH, POLY, SEED; ports clk, rst, load, step, state). It is instantiated three times.

## Test plan
- Reset, then start with SEED1=1 and out_ready=1 -> vector 0 in1=64'h1; vector 1 in1=64'hD800_0000_0000_0000; vector 2 in1=64'h6C00_0000_0000_0000.
- NUM_VEC=4, out_ready=1 -> exactly 4 valid cycles with vec_idx 0..3; done pulses once on the next cycle; busy then 0.
- out_ready low for 5 cycles at vec_idx=2 -> outputs and vec_idx frozen, no vector lost, and the sequence resumes with vector 2 handed over first.
- start pulsed mid-run -> ignored; the run still ends after NUM_VEC transfers. A second run repeats the first sequence bit-for-bit.
- rst asserted at vec_idx=10 -> out_valid and busy drop immediately; a new start yields in1 = SEED1 again.
- With GATE_VEC_GEN_WALK_EN -> first 64 vectors: in1=1<<k, in2=~in1, in3 alternating all-0/all-1; vector 64 has vec_idx=0 and in1=SEED1.
